// File: rtl/method_call_sequencer.sv
// Drives one req/busy/return method port: waits out a start-up delay, issues RUNS calls,
// checks each return value against EXPECTED and latches a pass/fail verdict.
module method_call_sequencer #(
  parameter int unsigned STARTUP_CYCLES = 100,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned RUNS           = 1,
  parameter int unsigned RET_WIDTH      = 1,
  parameter logic [RET_WIDTH-1:0] EXPECTED = RET_WIDTH'(32'd1)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 method_req,
  input  logic                 method_busy,
  input  logic [RET_WIDTH-1:0] method_return,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic                 mismatch,
  output logic [15:0]          runs_ok,
  output logic [RET_WIDTH-1:0] last_return
);

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_REQ       = 3'd1,
    ST_GUARD     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  localparam logic [31:0] START_LAST = 32'(STARTUP_CYCLES - 32'd1);
  // The flag register is loaded one edge early so timeout is already visible in the
  // cycle where the counter (0 in the REQ cycle) reads TIMEOUT_CYCLES-1.
  localparam logic [31:0] TMO_FLAG   = 32'(TIMEOUT_CYCLES - 32'd2);
  localparam logic [15:0] RUNS_W     = 16'(RUNS);

  state_t      state_r;
  logic [31:0] startup_cnt_r;
  logic [31:0] timeout_cnt_r;
  logic [15:0] run_idx_r;

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_STARTUP;
      startup_cnt_r <= 32'd0;
      timeout_cnt_r <= 32'd0;
      run_idx_r     <= 16'd0;
      method_req    <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      mismatch      <= 1'b0;
      runs_ok       <= 16'd0;
      last_return   <= '0;
    end else begin
      method_req <= 1'b0;
      case (state_r)
        ST_STARTUP: begin
          if (startup_cnt_r >= START_LAST) begin
            state_r       <= ST_REQ;
            method_req    <= 1'b1;
            timeout_cnt_r <= 32'd0;
          end else begin
            startup_cnt_r <= startup_cnt_r + 32'd1;
          end
        end
        ST_REQ: begin
          timeout_cnt_r <= timeout_cnt_r + 32'd1;
          state_r       <= ST_GUARD;
        end
        ST_GUARD: begin
          timeout_cnt_r <= timeout_cnt_r + 32'd1;
          state_r       <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!method_busy) begin
            last_return <= method_return;
            state_r     <= ST_CHECK;
          end else if (timeout_cnt_r >= TMO_FLAG) begin
            timeout <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            timeout_cnt_r <= timeout_cnt_r + 32'd1;
          end
        end
        ST_CHECK: begin
          if (last_return == EXPECTED) begin
            if (runs_ok != 16'hFFFF) begin
              runs_ok <= runs_ok + 16'd1;
            end
          end else begin
            mismatch <= 1'b1;
          end
          run_idx_r <= run_idx_r + 16'd1;
          if (run_idx_r + 16'd1 == RUNS_W) begin
            state_r <= ST_FINISH;
          end else begin
            state_r       <= ST_REQ;
            method_req    <= 1'b1;
            timeout_cnt_r <= 32'd0;
          end
        end
        ST_FINISH: begin
          done <= 1'b1;
          pass <= (runs_ok == RUNS_W) && !timeout && !mismatch;
        end
        default: begin
          state_r       <= ST_STARTUP;
          startup_cnt_r <= 32'd0;
          run_idx_r     <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_method_call_sequencer.sv
// Scoreboard bench: two sequencer instances (long start-up / short start-up with the minimum
// timeout) driven by a behavioural method DUT, checked against a per-call latency model.
module tb_method_call_sequencer;

  localparam int W  = 4;
  localparam int S0 = 100;
  localparam int T0 = 50;
  localparam int R0 = 4;
  localparam logic [W-1:0] E0 = 4'hA;
  localparam int S1 = 1;
  localparam int T1 = 3;
  localparam int R1 = 3;
  localparam logic [W-1:0] E1 = 4'h5;

  typedef struct {
    int done_cyc;
    int tmo_cyc;
    int pass;
    int tmo;
    int mm;
    int ok;
    int last;
  } fin_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic         req_a  [2];
  logic         busy_a [2];
  logic [W-1:0] ret_a  [2];
  logic         done_a [2];
  logic         pass_a [2];
  logic         tmo_a  [2];
  logic         mm_a   [2];
  logic [15:0]  ok_a   [2];
  logic [W-1:0] last_a [2];

  int   plan_l_q  [2][$];
  int   plan_v_q  [2][$];
  int   exp_req_q [2][$];
  fin_t fin_q     [2][$];
  int   reqs_seen [2];
  bit   fin_seen  [2];

  int errors = 0;
  int checks = 0;
  int cyc;

  method_call_sequencer #(
    .STARTUP_CYCLES(S0), .TIMEOUT_CYCLES(T0), .RUNS(R0), .RET_WIDTH(W), .EXPECTED(E0)
  ) u_long (
    .clk(clk), .reset(reset), .method_req(req_a[0]), .method_busy(busy_a[0]),
    .method_return(ret_a[0]), .done(done_a[0]), .pass(pass_a[0]), .timeout(tmo_a[0]),
    .mismatch(mm_a[0]), .runs_ok(ok_a[0]), .last_return(last_a[0])
  );

  method_call_sequencer #(
    .STARTUP_CYCLES(S1), .TIMEOUT_CYCLES(T1), .RUNS(R1), .RET_WIDTH(W), .EXPECTED(E1)
  ) u_short (
    .clk(clk), .reset(reset), .method_req(req_a[1]), .method_busy(busy_a[1]),
    .method_return(ret_a[1]), .done(done_a[1]), .pass(pass_a[1]), .timeout(tmo_a[1]),
    .mismatch(mm_a[1]), .runs_ok(ok_a[1]), .last_return(last_a[1])
  );

  always #5 clk = ~clk;

  // Cycle index: n after the n-th rising edge with reset low
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic int p_start(int g); return (g == 0) ? S0 : S1; endfunction
  function automatic int p_tmo(int g);   return (g == 0) ? T0 : T1; endfunction
  function automatic int p_runs(int g);  return (g == 0) ? R0 : R1; endfunction
  function automatic int p_exp(int g);   return (g == 0) ? int'(E0) : int'(E1); endfunction

  task automatic chk(string name, int g, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d (cycle %0d)", name, g, act, exp, cyc);
    end
  endtask

  // Reference: a call whose busy lasts L cycles after req ends in the cycle busy is
  // first seen low (never earlier than req+2); it is cut off if busy is still high
  // at req+max(2,T-2), with timeout visible one cycle later and done one after that.
  task automatic build(int g, int mode);
    int s, t, n, e, r, ok, lim, cd, l, v;
    bit to, mm;
    fin_t f;
    s = p_start(g); t = p_tmo(g); n = p_runs(g); e = p_exp(g);
    lim = (t - 2 > 2) ? t - 2 : 2;
    r = s; ok = 0; to = 0; mm = 0;
    f.last = 0; f.tmo_cyc = -1; f.done_cyc = -1;
    for (int i = 0; i < n; i++) begin
      v = e;
      case (mode)
        0: l = (g == 0) ? 20 : 1;
        1: l = 0;
        2: begin
          l = $urandom_range(0, (g == 0) ? 10 : 1);
          if (i == 1) v = e ^ 3;
        end
        3: l = (i == 1) ? ((g == 0) ? 1000 : lim) : ((g == 0) ? 5 : 1);
        4: l = lim - 1;
        default: begin
          case ($urandom_range(0, 9))
            0: l = lim;
            1: l = 0;
            2: l = lim - 1;
            default: l = $urandom_range(0, lim - 1);
          endcase
          if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 15);
        end
      endcase
      plan_l_q[g].push_back(l);
      plan_v_q[g].push_back(v);
      if (!to) begin
        exp_req_q[g].push_back(r);
        if (l >= lim) begin
          to = 1;
          f.tmo_cyc  = r + lim + 1;
          f.done_cyc = f.tmo_cyc + 1;
        end else begin
          cd = r + ((l + 1 > 2) ? l + 1 : 2);
          f.last = v;
          if (v == e) ok++;
          else mm = 1;
          if (i == n - 1) f.done_cyc = cd + 3;
          else r = cd + 2;
        end
      end
    end
    f.ok = ok; f.tmo = int'(to); f.mm = int'(mm);
    f.pass = int'((ok == n) && !to && !mm);
    fin_q[g].push_back(f);
  endtask

  // Behavioural method DUT: busy high for the planned cycles after req is sampled
  initial begin
    int rem [2];
    bit pend [2];
    for (int g = 0; g < 2; g++) begin
      rem[g] = 0; pend[g] = 0; busy_a[g] = 1'b0; ret_a[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (reset) begin
          rem[g] = 0; pend[g] = 0; busy_a[g] = 1'b0; ret_a[g] = '0;
        end else begin
          if (pend[g]) begin
            pend[g] = 0;
            if (plan_l_q[g].size() > 0) begin
              rem[g]   = plan_l_q[g].pop_front();
              ret_a[g] = W'(plan_v_q[g].pop_front());
            end else begin
              rem[g] = 0;
            end
          end
          busy_a[g] = (rem[g] > 0);
          if (rem[g] > 0) rem[g]--;
          if (req_a[g]) pend[g] = 1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever req, timeout or done is presented
  bit   prev_req  [2];
  bit   prev_tmo  [2];
  bit   prev_done [2];
  fin_t mf;
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        prev_req[g] = 0; prev_tmo[g] = 0; prev_done[g] = 0;
      end else begin
        if (req_a[g]) begin
          reqs_seen[g]++;
          chk("req_back_to_back", g, int'(prev_req[g]), 0);
          if (exp_req_q[g].size() == 0) chk("req_unexpected", g, 0, 1);
          else chk("req_cycle", g, cyc, exp_req_q[g].pop_front());
        end
        if (tmo_a[g] && !prev_tmo[g]) begin
          if (fin_q[g].size() == 0) chk("timeout_unexpected", g, 0, 1);
          else chk("timeout_cycle", g, cyc, fin_q[g][0].tmo_cyc);
        end
        if (pass_a[g]) chk("pass_needs_done", g, int'(done_a[g]), 1);
        if (done_a[g] && !prev_done[g]) begin
          if (fin_q[g].size() == 0) begin
            chk("done_unexpected", g, 0, 1);
          end else begin
            mf = fin_q[g].pop_front();
            chk("done_cycle", g, cyc, mf.done_cyc);
            chk("pass", g, int'(pass_a[g]), mf.pass);
            chk("timeout", g, int'(tmo_a[g]), mf.tmo);
            chk("mismatch", g, int'(mm_a[g]), mf.mm);
            chk("runs_ok", g, int'(ok_a[g]), mf.ok);
            chk("last_return", g, int'(last_a[g]), mf.last);
            chk("reqs_outstanding", g, exp_req_q[g].size(), 0);
          end
          fin_seen[g] = 1;
        end
        prev_req[g] = req_a[g]; prev_tmo[g] = tmo_a[g]; prev_done[g] = done_a[g];
      end
    end
  end

  task automatic check_zero(string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_req"},      g, int'(req_a[g]), 0);
      chk({tag, "_done"},     g, int'(done_a[g]), 0);
      chk({tag, "_pass"},     g, int'(pass_a[g]), 0);
      chk({tag, "_timeout"},  g, int'(tmo_a[g]), 0);
      chk({tag, "_mismatch"}, g, int'(mm_a[g]), 0);
      chk({tag, "_runs_ok"},  g, int'(ok_a[g]), 0);
      chk({tag, "_last"},     g, int'(last_a[g]), 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      plan_l_q[g].delete(); plan_v_q[g].delete();
      exp_req_q[g].delete(); fin_q[g].delete();
      reqs_seen[g] = 0; fin_seen[g] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero("rst");
  endtask

  task automatic start(int mode);
    do_reset();
    build(0, mode);
    build(1, mode);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_finish();
    for (int k = 0; k < 2000; k++) begin
      if (fin_seen[0] && fin_seen[1]) break;
      @(negedge clk);
    end
    chk("finish_within_budget", 0, int'(fin_seen[0] && fin_seen[1]), 1);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    for (int m = 0; m < 5; m++) begin
      start(m);
      wait_finish();
    end

    // Asynchronous reset during WAIT_DONE of the second call, then a clean rerun
    start(0);
    for (int k = 0; k < 600; k++) begin
      if (reqs_seen[0] >= 2) break;
      @(negedge clk);
    end
    chk("second_req_seen", 0, int'(reqs_seen[0] >= 2), 1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    start(0);
    wait_finish();

    for (int k = 0; k < 8; k++) begin
      start(9);
      wait_finish();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
